// File: rtl/cpu_int_arbiter_if.sv
// ----------------------------------------------------------------------------
// cpu_int_arbiter_if
// Bundles the request side and the Z80 interrupt side of the multi-source
// interrupt arbiter.
//
//   req      NUM_SRC  request lines, a rising edge is one event
//   mask     NUM_SRC  1 = source allowed to raise INT
//   m1       1        CPU M1, active high
//   iorq     1        CPU IORQ, active high
//   n_int    1        INT to the CPU, active low
//   int_src  SRC_W    index of the source being / last served
//   pending  NUM_SRC  latched events not yet served
//   int_ack  1        one-cycle strobe on an acknowledged INTA
//   vec_out  8        IM2 vector byte
//   vec_oe   1        1 = vec_out should be driven onto the data bus
//
// Modports: master = CPU / system side, slave = the arbiter itself.
// ----------------------------------------------------------------------------
interface cpu_int_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] mask;
   logic               m1;
   logic               iorq;
   logic               n_int;
   logic [SRC_W-1:0]   int_src;
   logic [NUM_SRC-1:0] pending;
   logic               int_ack;
   logic [7:0]         vec_out;
   logic               vec_oe;

   modport master (
      output req, mask, m1, iorq,
      input  n_int, int_src, pending, int_ack, vec_out, vec_oe
   );

   modport slave (
      input  req, mask, m1, iorq,
      output n_int, int_src, pending, int_ack, vec_out, vec_oe
   );
endinterface

// File: rtl/cpu_int_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_int_arbiter
// Multi-source Z80 maskable-interrupt generator. Rising edges on the request
// lines are latched as pending events. The lowest-numbered enabled pending
// source is served by pulling n_int low for at most INT_LEN cycles. An INTA
// cycle (m1 && iorq) ends the pulse early and retires the event. Consecutive
// pulses are separated by INT_GAP high cycles.
//
// Ports:
//   clkcpu  in  CPU clock, all state on the rising edge
//   rst_n   in  asynchronous active-low reset
//   bus     cpu_int_arbiter_if.slave (req, mask, m1, iorq in;
//           n_int, int_src, pending, int_ack, vec_out, vec_oe out)
//
// Optional feature macro: CPU_INT_ARBITER_IM2_EN
//   defined     -> vec_out/vec_oe supply an IM2 vector during INTA
//   not defined -> vec_oe = 0 and vec_out = 8'hFF (floating-bus value)
// ----------------------------------------------------------------------------
module cpu_int_arbiter #(
   parameter int          NUM_SRC     = 4,
   parameter int          SYNC_STAGES = 2,
   parameter int          INT_LEN     = 32,
   parameter int          INT_GAP     = 4,
   parameter int          RETRY       = 1,
   parameter logic [7:0]  VEC_BASE    = 8'hFF
) (
   input logic           clkcpu,
   input logic           rst_n,
   cpu_int_arbiter_if.slave bus
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [7:0] CNT_LAST = 8'(INT_LEN - 1);
   localparam logic [3:0] GAP_LAST = 4'(INT_GAP - 1);

   typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

   state_t             state;
   logic [7:0]         cnt;
   logic [3:0]         gcnt;
   logic               n_int_q;
   logic [SRC_W-1:0]   int_src_q;
   logic               int_ack_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] req_s;
   logic [NUM_SRC-1:0] req_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] cand;
   logic [NUM_SRC-1:0] clr;
   logic [SRC_W-1:0]   winner;
   logic               any_cand;
   logic               inta;
   logic               inta_d;
   logic               inta_rise;

   // Bring asynchronous request lines into the clkcpu domain; with zero stages
   // the inputs are assumed to be clkcpu-synchronous already.
   if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = bus.req;
   end else begin : g_sync
      logic [SYNC_STAGES*NUM_SRC-1:0] chain;
      always_ff @(posedge clkcpu or negedge rst_n) begin
         if (!rst_n) begin
            chain <= '0;
         end else begin
            chain[0 +: NUM_SRC] <= bus.req;
            for (int s = 1; s < SYNC_STAGES; s++) begin
               chain[s*NUM_SRC +: NUM_SRC] <= chain[(s-1)*NUM_SRC +: NUM_SRC];
            end
         end
      end
      assign req_s = chain[(SYNC_STAGES-1)*NUM_SRC +: NUM_SRC];
   end

   assign rise      = req_s & ~req_d;
   assign inta      = bus.m1 && bus.iorq;
   assign inta_rise = inta && !inta_d;
   assign cand      = pending_q & bus.mask;
   assign any_cand  = |cand;

   // Fixed priority: scanning from the top leaves the lowest set index.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (cand[i]) winner = SRC_W'(i);
      end
   end

   // Retire the served event on INTA, or on timeout when retries are off.
   always_comb begin
      clr = '0;
      if (state == ASSERT) begin
         if (inta_rise || (cnt == CNT_LAST && RETRY == 0)) begin
            clr = NUM_SRC'(1) << int_src_q;
         end
      end
   end

   // Main FSM. A new rising edge is ORed in after the clear so an event that
   // arrives while its own bit is being retired is never lost. The last GAP
   // cycle re-arbitrates so back-to-back pulses are exactly INT_GAP apart.
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         gcnt      <= '0;
         n_int_q   <= 1'b1;
         int_src_q <= '0;
         int_ack_q <= 1'b0;
         pending_q <= '0;
         req_d     <= '0;
         inta_d    <= 1'b0;
      end else begin
         req_d     <= req_s;
         inta_d    <= inta;
         int_ack_q <= 1'b0;
         pending_q <= (pending_q & ~clr) | rise;
         case (state)
            IDLE: begin
               if (any_cand) begin
                  state     <= ASSERT;
                  int_src_q <= winner;
                  n_int_q   <= 1'b0;
                  cnt       <= '0;
               end
            end
            ASSERT: begin
               if (inta_rise) begin
                  int_ack_q <= 1'b1;
                  n_int_q   <= 1'b1;
                  state     <= GAP;
                  gcnt      <= '0;
               end else if (cnt == CNT_LAST) begin
                  n_int_q   <= 1'b1;
                  state     <= GAP;
                  gcnt      <= '0;
               end else begin
                  cnt       <= cnt + 8'd1;
               end
            end
            GAP: begin
               if (gcnt == GAP_LAST) begin
                  if (any_cand) begin
                     state     <= ASSERT;
                     int_src_q <= winner;
                     n_int_q   <= 1'b0;
                     cnt       <= '0;
                  end else begin
                     state     <= IDLE;
                  end
               end else begin
                  gcnt <= gcnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.n_int   = n_int_q;
   assign bus.int_src = int_src_q;
   assign bus.int_ack = int_ack_q;
   assign bus.pending = pending_q;

`ifdef CPU_INT_ARBITER_IM2_EN
   logic       vec_hold;
   logic       vec_oe_c;
   logic [2:0] src3;

   // Keep the vector on the bus for the rest of the INTA cycle after the
   // FSM has already moved on to GAP; it drops as soon as IORQ does.
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         vec_hold <= 1'b0;
      end else begin
         vec_hold <= inta && (vec_hold || (state == ASSERT && inta_rise));
      end
   end

   assign vec_oe_c    = inta && (state == ASSERT || vec_hold);
   assign src3        = 3'(int_src_q);
   assign bus.vec_oe  = vec_oe_c;
   assign bus.vec_out = vec_oe_c ? ((VEC_BASE & 8'hF1) | {4'b0000, src3, 1'b0}) : 8'hFF;
`else
   // No vector logic: the bus floats high, which IM2 tables filled with
   // 8'hFF entries rely on.
   assign bus.vec_oe  = 1'b0;
   assign bus.vec_out = VEC_BASE | 8'hFF;
`endif

endmodule

// File: tb/tb_cpu_int_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_int_arbiter
// Self-checking bench for cpu_int_arbiter. Two instances share clock and
// reset: dut (RETRY=1) and dut_r0 (RETRY=0), both NUM_SRC=4, no synchroniser,
// INT_LEN=32, INT_GAP=4, VEC_BASE=8'hFF. A table of single-shot request
// patterns is followed by hand-written multi-cycle sequences.
// ----------------------------------------------------------------------------
module tb_cpu_int_arbiter;
   logic clkcpu;
   logic rst_n;

   int tests;
   int fails;

`ifdef CPU_INT_ARBITER_IM2_EN
   localparam bit IM2 = 1'b1;
`else
   localparam bit IM2 = 1'b0;
`endif

   cpu_int_arbiter_if #(.NUM_SRC(4)) ifc ();
   cpu_int_arbiter_if #(.NUM_SRC(4)) ifc_r ();

   cpu_int_arbiter #(
      .NUM_SRC(4), .SYNC_STAGES(0), .INT_LEN(32), .INT_GAP(4),
      .RETRY(1), .VEC_BASE(8'hFF)
   ) dut (
      .clkcpu(clkcpu),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   cpu_int_arbiter #(
      .NUM_SRC(4), .SYNC_STAGES(0), .INT_LEN(32), .INT_GAP(4),
      .RETRY(0), .VEC_BASE(8'hFF)
   ) dut_r0 (
      .clkcpu(clkcpu),
      .rst_n (rst_n),
      .bus   (ifc_r)
   );

   // 100 MHz-style free-running clock
   initial begin
      clkcpu = 1'b0;
      forever #5 clkcpu = ~clkcpu;
   end

   // Hard stop in case any sequence loses its way
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   typedef struct {
      logic [3:0] req;
      logic [3:0] mask;
      logic [3:0] pend;
      logic       fires;
      logic [1:0] src;
      logic [3:0] pend_after;
   } vec_t;

   vec_t vecs [7];

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clkcpu);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] mask,
                                input logic m1, input logic iorq);
      ifc.req  = req;
      ifc.mask = mask;
      ifc.m1   = m1;
      ifc.iorq = iorq;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reset both instances with quiet inputs
   task automatic doReset();
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
      ifc_r.req  = 4'h0;
      ifc_r.mask = 4'h0;
      ifc_r.m1   = 1'b0;
      ifc_r.iorq = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clkcpu);
      #2 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [7:0] vexp;
      int lowCnt;
      int highCnt;
      int gapCnt;
      int strayLow;

      tests = 0;
      fails = 0;
      rst_n = 1'b1;

      vecs[0] = '{req:4'b0001, mask:4'hF,    pend:4'b0001, fires:1'b1, src:2'd0, pend_after:4'b0000};
      vecs[1] = '{req:4'b0100, mask:4'hF,    pend:4'b0100, fires:1'b1, src:2'd2, pend_after:4'b0000};
      vecs[2] = '{req:4'b1010, mask:4'hF,    pend:4'b1010, fires:1'b1, src:2'd1, pend_after:4'b1000};
      vecs[3] = '{req:4'b1100, mask:4'b1011, pend:4'b1100, fires:1'b1, src:2'd3, pend_after:4'b0100};
      vecs[4] = '{req:4'b0001, mask:4'b0000, pend:4'b0001, fires:1'b0, src:2'd0, pend_after:4'b0001};
      vecs[5] = '{req:4'b1111, mask:4'b1110, pend:4'b1111, fires:1'b1, src:2'd1, pend_after:4'b1101};
      vecs[6] = '{req:4'b1000, mask:4'b1000, pend:4'b1000, fires:1'b1, src:2'd3, pend_after:4'b0000};

      // Reset values, sampled while reset is held
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
      ifc_r.req = 4'h0; ifc_r.mask = 4'h0; ifc_r.m1 = 1'b0; ifc_r.iorq = 1'b0;
      rst_n = 1'b0;
      #12;
      checkOutput("reset n_int",   32'(ifc.n_int),   32'h1);
      checkOutput("reset pending", 32'(ifc.pending), 32'h0);
      checkOutput("reset int_src", 32'(ifc.int_src), 32'h0);
      checkOutput("reset int_ack", 32'(ifc.int_ack), 32'h0);
      checkOutput("reset vec_oe",  32'(ifc.vec_oe),  32'h0);
      checkOutput("reset vec_out", 32'(ifc.vec_out), 32'hFF);

      // Table: one request pattern per entry, served by a one-cycle INTA
      for (int v = 0; v < 7; v++) begin
         doReset();
         applyStimulus(vecs[v].req, vecs[v].mask, 1'b0, 1'b0);
         tick();
         checkOutput($sformatf("v%0d pending", v), 32'(ifc.pending), 32'(vecs[v].pend));
         checkOutput($sformatf("v%0d n_int early", v), 32'(ifc.n_int), 32'h1);
         tick();
         checkOutput($sformatf("v%0d n_int", v), 32'(ifc.n_int), 32'(!vecs[v].fires));
         checkOutput($sformatf("v%0d int_src", v), 32'(ifc.int_src), 32'(vecs[v].src));
         if (vecs[v].fires) begin
            vexp = IM2 ? (8'hF1 | {4'b0000, 1'b0, vecs[v].src, 1'b0}) : 8'hFF;
            applyStimulus(4'h0, vecs[v].mask, 1'b1, 1'b1);
            #1;
            checkOutput($sformatf("v%0d vec_oe", v), 32'(ifc.vec_oe), 32'(IM2));
            checkOutput($sformatf("v%0d vec_out", v), 32'(ifc.vec_out), 32'(vexp));
            tick();
            checkOutput($sformatf("v%0d int_ack", v), 32'(ifc.int_ack), 32'h1);
            checkOutput($sformatf("v%0d n_int ack", v), 32'(ifc.n_int), 32'h1);
            checkOutput($sformatf("v%0d pend ack", v), 32'(ifc.pending), 32'(vecs[v].pend_after));
            checkOutput($sformatf("v%0d vec_oe ack", v), 32'(ifc.vec_oe), 32'(IM2));
            checkOutput($sformatf("v%0d vec_out ack", v), 32'(ifc.vec_out), 32'(vexp));
            applyStimulus(4'h0, vecs[v].mask, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("v%0d vec_oe off", v), 32'(ifc.vec_oe), 32'h0);
            checkOutput($sformatf("v%0d vec_out off", v), 32'(ifc.vec_out), 32'hFF);
         end
      end

      // T1: unacknowledged pulse is 32 low, 4 high, then retried
      doReset();
      applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("t1 first low", 32'(ifc.n_int), 32'h0);
      lowCnt = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (ifc.n_int) break;
         lowCnt++;
      end
      checkOutput("t1 low length", 32'(lowCnt), 32'd32);
      highCnt = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (!ifc.n_int) break;
         highCnt++;
      end
      checkOutput("t1 gap length", 32'(highCnt), 32'd4);
      checkOutput("t1 retry src", 32'(ifc.int_src), 32'd2);
      checkOutput("t1 retry pending", 32'(ifc.pending), 32'b0100);

      // T2: simultaneous edges, late two-cycle INTA, then the next source
      doReset();
      applyStimulus(4'b1010, 4'hF, 1'b0, 1'b0);
      tick();
      tick();
      repeat (10) tick();
      checkOutput("t2 still low", 32'(ifc.n_int), 32'h0);
      applyStimulus(4'b0000, 4'hF, 1'b1, 1'b1);
      tick();
      checkOutput("t2 int_ack", 32'(ifc.int_ack), 32'h1);
      checkOutput("t2 int_src", 32'(ifc.int_src), 32'd1);
      checkOutput("t2 pending", 32'(ifc.pending), 32'b1000);
      gapCnt = 1;
      tick();
      checkOutput("t2 ack once", 32'(ifc.int_ack), 32'h0);
      if (ifc.n_int) gapCnt++;
      applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!ifc.n_int) break;
         gapCnt++;
      end
      checkOutput("t2 gap length", 32'(gapCnt), 32'd4);
      checkOutput("t2 second src", 32'(ifc.int_src), 32'd3);
      checkOutput("t2 second low", 32'(ifc.n_int), 32'h0);

      // T3: masked event waits, unmasking raises INT one cycle later
      doReset();
      applyStimulus(4'b0001, 4'h0, 1'b0, 1'b0);
      repeat (4) tick();
      checkOutput("t3 masked n_int", 32'(ifc.n_int), 32'h1);
      checkOutput("t3 masked pending", 32'(ifc.pending), 32'b0001);
      applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
      tick();
      checkOutput("t3 unmask n_int", 32'(ifc.n_int), 32'h0);
      checkOutput("t3 unmask src", 32'(ifc.int_src), 32'd0);

      // INTA while idle is ignored
      doReset();
      applyStimulus(4'h0, 4'hF, 1'b1, 1'b1);
      tick();
      checkOutput("idle inta ack", 32'(ifc.int_ack), 32'h0);
      checkOutput("idle inta n_int", 32'(ifc.n_int), 32'h1);
      checkOutput("idle inta vec_oe", 32'(ifc.vec_oe), 32'h0);
      applyStimulus(4'h0, 4'hF, 1'b0, 1'b0);

      // T4: RETRY=0 drops the event on timeout; mask drop mid-pulse is ignored
      doReset();
      ifc_r.mask = 4'hF;
      ifc_r.req  = 4'b0100;
      tick();
      tick();
      checkOutput("t4 first low", 32'(ifc_r.n_int), 32'h0);
      lowCnt = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (lowCnt == 5) ifc_r.mask = 4'h0;
         if (ifc_r.n_int) break;
         lowCnt++;
      end
      ifc_r.mask = 4'hF;
      checkOutput("t4 low length", 32'(lowCnt), 32'd32);
      checkOutput("t4 pending dropped", 32'(ifc_r.pending), 32'h0);
      strayLow = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!ifc_r.n_int) strayLow++;
      end
      checkOutput("t4 no second pulse", 32'(strayLow), 32'd0);

      // T6: reset in the middle of a pulse
      doReset();
      applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
      tick();
      tick();
      repeat (4) tick();
      checkOutput("t6 low before reset", 32'(ifc.n_int), 32'h0);
      #1 rst_n = 1'b0;
      applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
      #1;
      checkOutput("t6 async n_int", 32'(ifc.n_int), 32'h1);
      checkOutput("t6 async pending", 32'(ifc.pending), 32'h0);
      @(posedge clkcpu);
      #2 rst_n = 1'b1;
      tick();
      tick();
      checkOutput("t6 idle n_int", 32'(ifc.n_int), 32'h1);
      checkOutput("t6 idle pending", 32'(ifc.pending), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
